// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller status inputs and stage control outputs
interface pipeline_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_is_md;
    logic       ex_branch_taken;
    logic       imem_ready;
    logic       mem_busy;
    logic       pc_en;
    logic       pc_redirect;
    logic       if_id_en;
    logic       if_id_valid_in;
    logic       id_ex_en;
    logic       id_ex_bubble;
    logic       ex_mem_en;
    logic       ex_mem_bubble;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_rd, ex_mem_read, ex_is_md, ex_branch_taken,
               imem_ready, mem_busy,
        input  pc_en, pc_redirect, if_id_en, if_id_valid_in, id_ex_en,
               id_ex_bubble, ex_mem_en, ex_mem_bubble, md_busy, md_done
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_rd, ex_mem_read, ex_is_md, ex_branch_taken,
               imem_ready, mem_busy,
        output pc_en, pc_redirect, if_id_en, if_id_valid_in, id_ex_en,
               id_ex_bubble, ex_mem_en, ex_mem_bubble, md_busy, md_done
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_hazard_ctrl_if.slave       hz
);
    typedef enum logic {RUN, MD_BUSY} fsm_t;

    localparam logic [5:0] MD_INIT = 6'(MD_LATENCY - 2);

    fsm_t       fsm;
    logic [5:0] md_cnt;
    logic       drop_next;

    logic load_use;
    logic md_stall;
    logic branch_act;

    assign load_use = hz.ex_valid & hz.ex_mem_read & (hz.ex_rd != 5'd0) & hz.id_valid &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    assign md_stall   = ((fsm == RUN) & hz.ex_valid & hz.ex_is_md) |
                        ((fsm == MD_BUSY) & (md_cnt != 6'd0));
    // A mul/div in EX cannot branch, so the stall masks any stray branch flag.
    assign branch_act = hz.ex_branch_taken & hz.ex_valid & ~md_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= RUN;
            md_cnt    <= 6'd0;
            drop_next <= 1'b0;
        end else if (!hz.mem_busy) begin
            if (branch_act) begin
                if (!hz.imem_ready)
                    drop_next <= 1'b1;
            end else if (hz.imem_ready) begin
                drop_next <= 1'b0;
            end
            case (fsm)
                RUN: begin
                    if (hz.ex_valid && hz.ex_is_md) begin
                        fsm    <= MD_BUSY;
                        md_cnt <= MD_INIT;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt != 6'd0)
                        md_cnt <= md_cnt - 6'd1;
                    else
                        fsm <= RUN;
                end
                default: fsm <= RUN;
            endcase
        end
    end

    always_comb begin
        hz.pc_en          = hz.imem_ready;
        hz.pc_redirect    = 1'b0;
        hz.if_id_en       = 1'b1;
        hz.if_id_valid_in = hz.imem_ready & ~drop_next;
        hz.id_ex_en       = 1'b1;
        hz.id_ex_bubble   = 1'b0;
        hz.ex_mem_en      = 1'b1;
        hz.ex_mem_bubble  = 1'b0;
        hz.md_busy        = 1'b0;
        hz.md_done        = 1'b0;
        if (rst) begin
            hz.pc_en          = 1'b0;
            hz.if_id_en       = 1'b0;
            hz.if_id_valid_in = 1'b0;
            hz.id_ex_en       = 1'b0;
            hz.id_ex_bubble   = 1'b1;
            hz.ex_mem_en      = 1'b0;
            hz.ex_mem_bubble  = 1'b1;
        end else if (hz.mem_busy) begin
            hz.pc_en     = 1'b0;
            hz.if_id_en  = 1'b0;
            hz.id_ex_en  = 1'b0;
            hz.ex_mem_en = 1'b0;
        end else if (md_stall) begin
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.id_ex_en      = 1'b0;
            hz.ex_mem_bubble = 1'b1;
            hz.md_busy       = 1'b1;
        end else if (branch_act) begin
            hz.pc_en          = 1'b1;
            hz.pc_redirect    = 1'b1;
            hz.if_id_valid_in = 1'b0;
            hz.id_ex_bubble   = 1'b1;
        end else if (load_use) begin
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end else if (!hz.imem_ready) begin
            hz.pc_en          = 1'b0;
            hz.if_id_valid_in = 1'b0;
        end
        // Final mul/div cycle: default enables let the result advance.
        if (!rst && (fsm == MD_BUSY) && (md_cnt == 6'd0) && !hz.mem_busy)
            hz.md_done = 1'b1;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    // {pc_en, pc_redirect, if_id_en, if_id_valid_in, id_ex_en, id_ex_bubble,
    //  ex_mem_en, ex_mem_bubble, md_busy, md_done}
    logic [9:0] outs;
    assign outs = {hz.pc_en, hz.pc_redirect, hz.if_id_en, hz.if_id_valid_in, hz.id_ex_en,
                   hz.id_ex_bubble, hz.ex_mem_en, hz.ex_mem_bubble, hz.md_busy, hz.md_done};

    localparam logic [9:0] V_RUN    = 10'b1011101000;
    localparam logic [9:0] V_RST    = 10'b0000010100;
    localparam logic [9:0] V_LU     = 10'b0001111000;
    localparam logic [9:0] V_MD     = 10'b0001001110;
    localparam logic [9:0] V_MD_NI  = 10'b0000001110;
    localparam logic [9:0] V_DONE   = 10'b1011101001;
    localparam logic [9:0] V_FRZ    = 10'b0001000000;
    localparam logic [9:0] V_BR     = 10'b1110111000;
    localparam logic [9:0] V_IWAIT  = 10'b0010101000;
    localparam logic [9:0] V_DROP   = 10'b1010101000;

    task automatic idle;
        hz.id_valid = 1'b0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
        hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
        hz.ex_valid = 1'b0; hz.ex_rd = 5'd0; hz.ex_mem_read = 1'b0;
        hz.ex_is_md = 1'b0; hz.ex_branch_taken = 1'b0;
        hz.imem_ready = 1'b1; hz.mem_busy = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        @(negedge clk);
        if (outs !== V_RST) begin $display("FAIL reset_outputs: got %b want %b", outs, V_RST); fails++; end
        checks++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL post_reset_run: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
    endtask

    task automatic test_load_use;
        idle();
        hz.ex_valid = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
        hz.id_valid = 1'b1; hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1;
        hz.id_rs2 = 5'd1; hz.id_uses_rs2 = 1'b1;
        @(negedge clk);
        if (outs !== V_LU) begin $display("FAIL load_use_rs1: got %b want %b", outs, V_LU); fails++; end
        checks++;
        next_cycle();
        hz.ex_valid = 1'b0;
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL load_use_cleared: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
        hz.ex_valid = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0;
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL load_use_x0: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
        hz.ex_rd = 5'd5; hz.id_rs1 = 5'd7; hz.id_rs2 = 5'd5;
        @(negedge clk);
        if (outs !== V_LU) begin $display("FAIL load_use_rs2: got %b want %b", outs, V_LU); fails++; end
        checks++;
        next_cycle();
        hz.id_uses_rs2 = 1'b0;
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL load_use_rs2_unused: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
        idle();
    endtask

    task automatic test_mul_div;
        logic [9:0] exp;
        idle();
        hz.ex_valid = 1'b1; hz.ex_is_md = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (i < 3) ? V_MD : V_DONE;
            @(negedge clk);
            if (outs !== exp) begin $display("FAIL md_plain cyc%0d: got %b want %b", i, outs, exp); fails++; end
            checks++;
            next_cycle();
        end
        idle();
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL md_back_to_run: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
    endtask

    task automatic test_mul_div_freeze;
        logic [9:0] exp;
        idle();
        hz.ex_valid = 1'b1; hz.ex_is_md = 1'b1;
        for (int i = 0; i < 6; i++) begin
            hz.mem_busy = (i == 2 || i == 3);
            exp = (i == 2 || i == 3) ? V_FRZ : ((i == 5) ? V_DONE : V_MD);
            @(negedge clk);
            if (outs !== exp) begin $display("FAIL md_freeze cyc%0d: got %b want %b", i, outs, exp); fails++; end
            checks++;
            next_cycle();
        end
        hz.mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = (i < 3) ? V_MD : V_DONE;
            @(negedge clk);
            if (outs !== exp) begin $display("FAIL md_back_to_back cyc%0d: got %b want %b", i, outs, exp); fails++; end
            checks++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_branch;
        idle();
        hz.ex_valid = 1'b1; hz.ex_branch_taken = 1'b1;
        @(negedge clk);
        if (outs !== V_BR) begin $display("FAIL branch_ready: got %b want %b", outs, V_BR); fails++; end
        checks++;
        next_cycle();
        idle();
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL branch_no_drop: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
    endtask

    task automatic test_branch_fetch_wait;
        idle();
        hz.ex_valid = 1'b1; hz.ex_branch_taken = 1'b1; hz.imem_ready = 1'b0;
        @(negedge clk);
        if (outs !== V_BR) begin $display("FAIL branch_wait_redirect: got %b want %b", outs, V_BR); fails++; end
        checks++;
        next_cycle();
        idle();
        hz.imem_ready = 1'b0;
        @(negedge clk);
        if (outs !== V_IWAIT) begin $display("FAIL branch_wait_stall: got %b want %b", outs, V_IWAIT); fails++; end
        checks++;
        next_cycle();
        hz.imem_ready = 1'b1;
        @(negedge clk);
        if (outs !== V_DROP) begin $display("FAIL branch_wait_squash: got %b want %b", outs, V_DROP); fails++; end
        checks++;
        next_cycle();
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL branch_wait_next_valid: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
    endtask

    task automatic test_freeze_priority;
        idle();
        hz.ex_valid = 1'b1; hz.ex_branch_taken = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9;
        hz.id_valid = 1'b1; hz.id_rs1 = 5'd9; hz.id_uses_rs1 = 1'b1;
        hz.mem_busy = 1'b1;
        @(negedge clk);
        if (outs !== V_FRZ) begin $display("FAIL freeze_all: got %b want %b", outs, V_FRZ); fails++; end
        checks++;
        next_cycle();
        hz.mem_busy = 1'b0;
        @(negedge clk);
        if (outs !== V_BR) begin $display("FAIL freeze_then_branch: got %b want %b", outs, V_BR); fails++; end
        checks++;
        next_cycle();
        idle();
    endtask

    task automatic test_reset_mid_md;
        idle();
        hz.ex_valid = 1'b1; hz.ex_branch_taken = 1'b1; hz.imem_ready = 1'b0;
        @(negedge clk);
        if (outs !== V_BR) begin $display("FAIL rst_md_branch: got %b want %b", outs, V_BR); fails++; end
        checks++;
        next_cycle();
        hz.ex_branch_taken = 1'b0; hz.ex_is_md = 1'b1;
        @(negedge clk);
        if (outs !== V_MD_NI) begin $display("FAIL rst_md_start: got %b want %b", outs, V_MD_NI); fails++; end
        checks++;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        if (outs !== V_RST) begin $display("FAIL rst_md_forced: got %b want %b", outs, V_RST); fails++; end
        checks++;
        next_cycle();
        rst = 1'b0;
        idle();
        @(negedge clk);
        if (outs !== V_RUN) begin $display("FAIL rst_md_cleared: got %b want %b", outs, V_RUN); fails++; end
        checks++;
        next_cycle();
    endtask

    initial begin
        idle();
        next_cycle();
        test_reset();
        test_load_use();
        test_mul_div();
        test_mul_div_freeze();
        test_branch();
        test_branch_fetch_wait();
        test_freeze_priority();
        test_reset_mid_md();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
